// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
// Holds the MDUOp encodings used by both the controller and the unit,
// and the IDLE/BUSY state encoding.
package mdu_pkg;

    localparam int unsigned MDU_OP_W = 3;

    localparam logic [MDU_OP_W-1:0] MDU_NONE  = 3'd0;
    localparam logic [MDU_OP_W-1:0] MDU_MULT  = 3'd1;
    localparam logic [MDU_OP_W-1:0] MDU_MULTU = 3'd2;
    localparam logic [MDU_OP_W-1:0] MDU_DIV   = 3'd3;
    localparam logic [MDU_OP_W-1:0] MDU_DIVU  = 3'd4;
    localparam logic [MDU_OP_W-1:0] MDU_MTHI  = 3'd5;
    localparam logic [MDU_OP_W-1:0] MDU_MTLO  = 3'd6;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

endpackage : mdu_pkg

// File: rtl/mdu_core.sv
// mdu_core: combinational arithmetic for mult/multu/div/divu.
// Ports:
//   op_i       - latched MDUOp
//   a_i, b_i   - latched operands (rs / rt)
//   hi_next_o  - value to commit to HI (product upper half / remainder)
//   lo_next_o  - value to commit to LO (product lower half / quotient)
//   div_zero_o - divide with a zero divisor; HI/LO must not be written
module mdu_core
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [MDU_OP_W-1:0] op_i,
    input  logic [WIDTH-1:0]    a_i,
    input  logic [WIDTH-1:0]    b_i,
    output logic [WIDTH-1:0]    hi_next_o,
    output logic [WIDTH-1:0]    lo_next_o,
    output logic                div_zero_o
);

    localparam int unsigned PW = 2 * WIDTH;

    logic [PW-1:0]    prod_s;
    logic [PW-1:0]    prod_u;
    logic             b_is_zero;
    logic [WIDTH-1:0] div_u;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH-1:0] abs_b_safe;
    logic [WIDTH-1:0] q_u;
    logic [WIDTH-1:0] r_u;
    logic [WIDTH-1:0] q_m;
    logic [WIDTH-1:0] r_m;
    logic [WIDTH-1:0] q_s;
    logic [WIDTH-1:0] r_s;

    // Sign-extended operands multiplied modulo 2^PW give the signed product.
    assign prod_s = {{WIDTH{a_i[WIDTH-1]}}, a_i} * {{WIDTH{b_i[WIDTH-1]}}, b_i};
    assign prod_u = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};

    // Zero divisor is replaced by 1 so the dividers never see x/0.
    assign b_is_zero = (b_i == '0);
    assign div_u     = b_is_zero ? WIDTH'(1) : b_i;
    assign q_u       = a_i / div_u;
    assign r_u       = a_i % div_u;

    // Signed divide on magnitudes; MIN's magnitude is exact as unsigned.
    assign abs_a      = a_i[WIDTH-1] ? (WIDTH'(0) - a_i) : a_i;
    assign abs_b      = b_i[WIDTH-1] ? (WIDTH'(0) - b_i) : b_i;
    assign abs_b_safe = b_is_zero ? WIDTH'(1) : abs_b;
    assign q_m        = abs_a / abs_b_safe;
    assign r_m        = abs_a % abs_b_safe;

    // Truncate toward zero; remainder follows the dividend's sign.
    // MIN / -1 yields magnitude MIN with a positive sign, i.e. wraps to MIN.
    assign q_s = (a_i[WIDTH-1] ^ b_i[WIDTH-1]) ? (WIDTH'(0) - q_m) : q_m;
    assign r_s = a_i[WIDTH-1] ? (WIDTH'(0) - r_m) : r_m;

    // Result select
    always_comb begin
        hi_next_o  = '0;
        lo_next_o  = '0;
        div_zero_o = 1'b0;
        case (op_i)
            MDU_MULT: begin
                hi_next_o = prod_s[PW-1:WIDTH];
                lo_next_o = prod_s[WIDTH-1:0];
            end
            MDU_MULTU: begin
                hi_next_o = prod_u[PW-1:WIDTH];
                lo_next_o = prod_u[WIDTH-1:0];
            end
            MDU_DIV: begin
                hi_next_o  = r_s;
                lo_next_o  = q_s;
                div_zero_o = b_is_zero;
            end
            MDU_DIVU: begin
                hi_next_o  = r_u;
                lo_next_o  = q_u;
                div_zero_o = b_is_zero;
            end
            default: ;
        endcase
    end

endmodule : mdu_core

// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle multiply/divide unit with HI/LO registers.
// Ports:
//   clk, reset   - clock (rising edge), asynchronous active-high reset
//   start        - issue strobe
//   MDUOp        - operation (none/mult/multu/div/divu/mthi/mtlo)
//   In1, In2     - rs/dividend/mthi-mtlo source, rt/divisor
//   HI, LO       - registered HI/LO (mfhi/mflo source)
//   busy         - registered, high while a mult/div is in flight
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [MDU_OP_W-1:0] MDUOp,
    input  logic [WIDTH-1:0]    In1,
    input  logic [WIDTH-1:0]    In2,
    output logic [WIDTH-1:0]    HI,
    output logic [WIDTH-1:0]    LO,
    output logic                busy
);

    localparam int unsigned MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    mdu_state_e          state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [MDU_OP_W-1:0] op_q;
    logic [WIDTH-1:0]    a_q;
    logic [WIDTH-1:0]    b_q;
    logic [WIDTH-1:0]    hi_q;
    logic [WIDTH-1:0]    lo_q;
    logic                busy_q;

    logic [WIDTH-1:0]    hi_next;
    logic [WIDTH-1:0]    lo_next;
    logic                div_zero;

    // Arithmetic works only from latched operands, so In1/In2 may change freely.
    mdu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op_i       (op_q),
        .a_i        (a_q),
        .b_i        (b_q),
        .hi_next_o  (hi_next),
        .lo_next_o  (lo_next),
        .div_zero_o (div_zero)
    );

    // Control FSM, operation counter and HI/LO registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= MDU_NONE;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        case (MDUOp)
                            MDU_MULT, MDU_MULTU: begin
                                op_q    <= MDUOp;
                                a_q     <= In1;
                                b_q     <= In2;
                                cnt_q   <= CNT_W'(MUL_CYCLES);
                                state_q <= ST_BUSY;
                                busy_q  <= 1'b1;
                            end
                            MDU_DIV, MDU_DIVU: begin
                                op_q    <= MDUOp;
                                a_q     <= In1;
                                b_q     <= In2;
                                cnt_q   <= CNT_W'(DIV_CYCLES);
                                state_q <= ST_BUSY;
                                busy_q  <= 1'b1;
                            end
                            MDU_MTHI: hi_q <= In1;
                            MDU_MTLO: lo_q <= In1;
                            default: ;
                        endcase
                    end
                end
                ST_BUSY: begin
                    // Any start seen here is dropped; the stall logic should prevent it.
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        if (!div_zero) begin
                            hi_q <= hi_next;
                            lo_q <= lo_next;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign HI   = hi_q;
    assign LO   = lo_q;
    assign busy = busy_q;

endmodule : mul_div_unit
